// File: rtl/retire_freelist_pkg.sv
// Shared sizing and types for the retirement map / physical register free list.
package retire_freelist_pkg;
    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS            = 64;
    localparam int PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS);
    localparam int ARCH_REGS            = 32;
    localparam int ARCH_ADDR_WIDTH      = $clog2(ARCH_REGS);

    typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_reg_t;
    typedef logic [PHYS_REGS_ADDR_WIDTH:0]   free_count_t;
    typedef logic [ARCH_ADDR_WIDTH-1:0]      arch_reg_t;
    typedef logic [DISPATCH_WIDTH-1:0]       lane_mask_t;

    // Number of set bits in mask below bit position lane; lane == DISPATCH_WIDTH gives the full popcount.
    function automatic free_count_t count_below(input lane_mask_t mask, input int lane);
        free_count_t n;
        n = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (i < lane && mask[i]) n = n + free_count_t'(1);
        end
        return n;
    endfunction
endpackage

// File: rtl/retire_freelist_fifo.sv
// Circular free list with packed multi-lane push (at tail) and pop (from head).
module retire_freelist_fifo
    import retire_freelist_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  lane_mask_t                       push_en,
    input  phys_reg_t [DISPATCH_WIDTH-1:0]   push_data,
    input  lane_mask_t                       pop_req,
    input  logic                             pop_fire,
    output phys_reg_t [DISPATCH_WIDTH-1:0]   pop_data,
    output free_count_t                      count
);
    localparam int INIT_FREE = PHYS_REGS - ARCH_REGS;

    phys_reg_t   mem [PHYS_REGS];
    phys_reg_t   head;
    phys_reg_t   tail;
    free_count_t n_push;
    free_count_t n_pop;

    assign n_push = count_below(push_en, DISPATCH_WIDTH);
    assign n_pop  = pop_fire ? count_below(pop_req, DISPATCH_WIDTH) : '0;

    always_comb begin
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            pop_data[w] = mem[head + phys_reg_t'(count_below(pop_req, w))];
        end
    end

    // Freed regs become visible only after this edge: no push-to-pop bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                mem[i] <= (i < INIT_FREE) ? phys_reg_t'(ARCH_REGS + i) : '0;
            end
            head  <= '0;
            tail  <= phys_reg_t'(INIT_FREE);
            count <= free_count_t'(INIT_FREE);
        end else begin
            for (int w = 0; w < DISPATCH_WIDTH; w++) begin
                if (push_en[w]) mem[tail + phys_reg_t'(count_below(push_en, w))] <= push_data[w];
            end
            head  <= head + phys_reg_t'(n_pop);
            tail  <= tail + phys_reg_t'(n_push);
            count <= count + n_push - n_pop;
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        (int'(count) + int'(n_push)) <= PHYS_REGS);
    underflow_a: assert property (@(posedge clk) disable iff (rst)
        n_pop <= count);
endmodule

// File: rtl/retire_freelist.sv
// Retirement rename map plus physical register free list fed by the ROB commit port.
module retire_freelist
    import retire_freelist_pkg::*;
(
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DISPATCH_WIDTH-1:0]                           commit_en,
    input  logic [DISPATCH_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0]      commit_arch_rd,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd,
    input  logic [DISPATCH_WIDTH-1:0]                           alloc_req,
    output logic                                                alloc_ready,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] alloc_phys_rd,
    output logic [PHYS_REGS_ADDR_WIDTH:0]                       free_count,
    input  logic [ARCH_ADDR_WIDTH-1:0]                          rmap_arch,
    output logic [PHYS_REGS_ADDR_WIDTH-1:0]                     rmap_phys
);
    phys_reg_t                       rmap [ARCH_REGS];
    phys_reg_t [DISPATCH_WIDTH-1:0]  freed;
    free_count_t                     count;
    logic                            alloc_fire;

    // Alloc handshake: the bundle fires when alloc_ready && |alloc_req; requests seen while
    // !alloc_ready are ignored and the requester must hold them. Commit lanes are always accepted.
    assign alloc_ready = (count >= free_count_t'(DISPATCH_WIDTH));
    assign alloc_fire  = alloc_ready && (|alloc_req);
    assign free_count  = count;
    assign rmap_phys   = rmap[rmap_arch];

    // A younger lane writing the same arch reg frees the older lane's phys reg, not the stale map entry.
    always_comb begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            freed[k] = rmap[commit_arch_rd[k]];
            if (commit_arch_rd[k] == '0) begin
                freed[k] = commit_phys_rd[k];
            end else begin
                for (int j = 0; j < DISPATCH_WIDTH; j++) begin
                    if (j < k && commit_en[j] && commit_arch_rd[j] == commit_arch_rd[k])
                        freed[k] = commit_phys_rd[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) rmap[i] <= phys_reg_t'(i);
        end else begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (commit_en[k] && commit_arch_rd[k] != '0)
                    rmap[commit_arch_rd[k]] <= commit_phys_rd[k];
            end
        end
    end

    retire_freelist_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_en   (commit_en),
        .push_data (freed),
        .pop_req   (alloc_req),
        .pop_fire  (alloc_fire),
        .pop_data  (alloc_phys_rd),
        .count     (count)
    );
endmodule
